grid_action_decoder: RTL and testbench

- Recovers the movement action taken at each step of a grid-world trajectory from the stream of visited states.
- Inverse of the next-state selector: given consecutive states (prev, cur), it emits the action code that produced cur from prev, or flags the transition as stay/illegal.
- Sits between the episode state logger and the Q-table update path.
- Streaming valid/ready on both sides, one-entry output register, one transition per cycle.

---
 rtl/grid_pkg.sv | 20 ++
 rtl/grid_step_decode.sv | 53 +++++
 rtl/grid_action_decoder.sv | 156 +++++++++++++++
 tb/tb_grid_action_decoder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared grid-world definitions: default geometry, action encoding and the
// decoder FSM state type.
package grid_pkg;

  localparam int GRID_W_DEF = 5;
  localparam int GRID_H_DEF = 5;

  localparam logic [3:0] ACT_RIGHT   = 4'd0;
  localparam logic [3:0] ACT_UP      = 4'd1;
  localparam logic [3:0] ACT_LEFT    = 4'd2;
  localparam logic [3:0] ACT_DOWN    = 4'd3;
  localparam logic [3:0] ACT_STAY    = 4'd4;
  localparam logic [3:0] ACT_ILLEGAL = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } grid_state_e;

endpackage

// File: rtl/grid_step_decode.sv
// Combinational inverse of the next-state selector: maps a (prev, cur) state
// pair to the single-step action that produced it, or flags it as illegal.
module grid_step_decode
  import grid_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int STATE_W = 6,
  parameter int ACT_W   = 4
) (
  input  logic [STATE_W-1:0] prev_i,
  input  logic [STATE_W-1:0] cur_i,
  output logic [ACT_W-1:0]   action_o,
  output logic               err_o
);

  localparam int NCELL = GRID_W * GRID_H;

  int  p_idx, c_idx;
  int  p_row, p_col, c_row, c_col;
  logic both_in_range;

  always_comb begin
    p_idx = int'(prev_i) - 1;
    c_idx = int'(cur_i) - 1;
    p_row = p_idx / GRID_W;
    p_col = p_idx % GRID_W;
    c_row = c_idx / GRID_W;
    c_col = c_idx % GRID_W;
    // state 0 maps to index -1, so one lower-bound test covers it
    both_in_range = (p_idx >= 0) && (p_idx < NCELL) && (c_idx >= 0) && (c_idx < NCELL);

    action_o = ACT_W'(ACT_ILLEGAL);
    err_o    = 1'b1;
    if (both_in_range) begin
      err_o = 1'b0;
      if (c_idx == p_idx) begin
        action_o = ACT_W'(ACT_STAY);
      end else if ((c_row == p_row) && (c_col == p_col + 1)) begin
        action_o = ACT_W'(ACT_RIGHT);
      end else if ((c_row == p_row) && (c_col == p_col - 1)) begin
        action_o = ACT_W'(ACT_LEFT);
      end else if ((c_col == p_col) && (c_row == p_row - 1)) begin
        action_o = ACT_W'(ACT_UP);
      end else if ((c_col == p_col) && (c_row == p_row + 1)) begin
        action_o = ACT_W'(ACT_DOWN);
      end else begin
        err_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_action_decoder.sv
// Streams visited states in, emits the action taken between consecutive
// states through a one-entry output register with per-episode step counting.
module grid_action_decoder
  import grid_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int STATE_W = 6,
  parameter int ACT_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACT_W-1:0]   out_action,
  output logic [STATE_W-1:0] out_from,
  output logic [STATE_W-1:0] out_to,
  output logic               out_err,
  output logic               out_last,
  output logic [CNT_W-1:0]   step_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  // state    | meaning
  // ST_IDLE  | no previous state held; next beat only seeds prev
  // ST_TRACK | prev held; each beat decodes (prev, beat) into the output

  grid_state_e        state_q, state_d;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic               first_q, first_d;
  logic               valid_q, valid_d;
  logic [ACT_W-1:0]   act_q, act_d;
  logic [STATE_W-1:0] from_q, from_d;
  logic [STATE_W-1:0] to_q, to_d;
  logic               err_q, err_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]   errc_q, errc_d;

  logic [ACT_W-1:0]   dec_action;
  logic               dec_err;
  logic               accept;

  grid_step_decode #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .STATE_W(STATE_W),
    .ACT_W  (ACT_W)
  ) u_step_decode (
    .prev_i  (prev_q),
    .cur_i   (in_state),
    .action_o(dec_action),
    .err_o   (dec_err)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    first_d = first_q;
    valid_d = valid_q;
    act_d   = act_q;
    from_d  = from_q;
    to_d    = to_q;
    err_d   = err_q;
    last_d  = last_q;
    step_d  = step_q;
    errc_d  = errc_q;

    // payload is left in place after a consume so it never glitches
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (!in_last) begin
            prev_d  = in_state;
            first_d = 1'b1;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          valid_d = 1'b1;
          act_d   = dec_action;
          from_d  = prev_q;
          to_d    = in_state;
          err_d   = dec_err;
          last_d  = in_last;
          first_d = 1'b0;
          if (first_q) begin
            step_d = CNT_W'(1);
          end else if (!(&step_q)) begin
            step_d = step_q + CNT_W'(1);
          end
          if (dec_err && !(&errc_q)) begin
            errc_d = errc_q + CNT_W'(1);
          end
          if (in_last) begin
            prev_d  = '0;
            state_d = ST_IDLE;
          end else begin
            prev_d = in_state;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      act_q   <= '0;
      from_q  <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      step_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      first_q <= first_d;
      valid_q <= valid_d;
      act_q   <= act_d;
      from_q  <= from_d;
      to_q    <= to_d;
      err_q   <= err_d;
      last_q  <= last_d;
      step_q  <= step_d;
      errc_q  <= errc_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_action = act_q;
  assign out_from   = from_q;
  assign out_to     = to_q;
  assign out_err    = err_q;
  assign out_last   = last_q;
  assign step_cnt   = step_q;
  assign err_cnt    = errc_q;

endmodule

// File: tb/tb_grid_action_decoder.sv
// Bench for grid_action_decoder: directed episodes plus randomized trajectories
// against a coordinate-based reference model.
module tb_grid_action_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_state;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_action;
  logic [5:0] out_from;
  logic [5:0] out_to;
  logic       out_err;
  logic       out_last;
  logic [7:0] step_cnt;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  grid_action_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_action(out_action),
    .out_from  (out_from),
    .out_to    (out_to),
    .out_err   (out_err),
    .out_last  (out_last),
    .step_cnt  (step_cnt),
    .err_cnt   (err_cnt)
  );

  typedef struct packed {
    logic [3:0] act;
    logic [5:0] from;
    logic [5:0] to;
    logic       err;
    logic       last;
    logic [7:0] step;
    logic [7:0] errc;
  } obs_t;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t cap_q[$];

  // record every output handshake; the transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      cap_q.push_back('{out_action, out_from, out_to, out_err, out_last, step_cnt, err_cnt});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int ref_action(input int p, input int c);
    int pr, pc, cr, cc;
    if (p < 1 || p > 25 || c < 1 || c > 25) return 15;
    pr = (p - 1) / 5;  pc = (p - 1) % 5;
    cr = (c - 1) / 5;  cc = (c - 1) % 5;
    if (pr == cr && pc == cc)     return 4;
    if (pr == cr && cc == pc + 1) return 0;
    if (pr == cr && cc == pc - 1) return 2;
    if (pc == cc && cr == pr - 1) return 1;
    if (pc == cc && cr == pr + 1) return 3;
    return 15;
  endfunction

  task automatic send_beat(input int s, input bit last);
    bit acc;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_state = 6'(s);
    in_last  = last;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: beat %0d never accepted, required accept within 64 cycles", s);
    end
  endtask

  task automatic wait_drain(input int n);
    for (int t = 0; t < 60 && cap_q.size() < n; t++) @(negedge clk);
    vectors++;
    if (cap_q.size() < n) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d outputs, required %0d", cap_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_handshake: in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
    vectors++;
    if ({out_action, out_from, out_to, out_err, out_last} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_payload: act=%0d from=%0d to=%0d err=%b last=%b required all 0",
               out_action, out_from, out_to, out_err, out_last);
    end
    vectors++;
    if ({step_cnt, err_cnt} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_counters: step=%0d err=%0d required 0 0", step_cnt, err_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap_q.delete();
  endtask

  task automatic test_basic_moves();
    int ex_act[4] = '{0, 1, 2, 3};
    int ex_from[4] = '{7, 8, 3, 2};
    int ex_to[4] = '{8, 3, 2, 7};
    out_ready = 1'b1;
    send_beat(7, 0); send_beat(8, 0); send_beat(3, 0); send_beat(2, 0); send_beat(7, 1);
    wait_drain(4);
    vectors++;
    if (cap_q.size() != 4) begin
      miscompares++;
      $display("FAIL basic_count: got %0d outputs required 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (cap_q[i].act !== 4'(ex_act[i]) || cap_q[i].from !== 6'(ex_from[i]) ||
            cap_q[i].to !== 6'(ex_to[i]) || cap_q[i].err !== 1'b0 ||
            cap_q[i].last !== (i == 3) || cap_q[i].step !== 8'(i + 1) || cap_q[i].errc !== 8'd0) begin
          miscompares++;
          $display("FAIL basic_out%0d: act=%0d %0d->%0d err=%b last=%b step=%0d errc=%0d required act=%0d %0d->%0d step=%0d",
                   i, cap_q[i].act, cap_q[i].from, cap_q[i].to, cap_q[i].err, cap_q[i].last,
                   cap_q[i].step, cap_q[i].errc, ex_act[i], ex_from[i], ex_to[i], i + 1);
        end
      end
    end
    cap_q.delete();
  endtask

  task automatic test_illegal_wrap();
    int ex_act[4] = '{15, 1, 4, 15};
    int ex_errc[4] = '{1, 1, 1, 2};
    out_ready = 1'b1;
    send_beat(5, 0); send_beat(6, 0); send_beat(1, 0); send_beat(1, 0); send_beat(25, 1);
    wait_drain(4);
    vectors++;
    if (cap_q.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d outputs required 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (cap_q[i].act !== 4'(ex_act[i]) || cap_q[i].err !== (ex_act[i] == 15) ||
            cap_q[i].step !== 8'(i + 1) || cap_q[i].errc !== 8'(ex_errc[i])) begin
          miscompares++;
          $display("FAIL wrap_out%0d: act=%0d err=%b step=%0d errc=%0d required act=%0d step=%0d errc=%0d",
                   i, cap_q[i].act, cap_q[i].err, cap_q[i].step, cap_q[i].errc,
                   ex_act[i], i + 1, ex_errc[i]);
        end
      end
    end
    cap_q.delete();
  endtask

  task automatic test_out_of_range();
    int ex_from[3] = '{3, 0, 26};
    int ex_to[3] = '{0, 26, 21};
    out_ready = 1'b1;
    send_beat(3, 0); send_beat(0, 0); send_beat(26, 0); send_beat(21, 1);
    wait_drain(3);
    vectors++;
    if (cap_q.size() != 3) begin
      miscompares++;
      $display("FAIL range_count: got %0d outputs required 3", cap_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (cap_q[i].act !== 4'd15 || cap_q[i].err !== 1'b1 || cap_q[i].from !== 6'(ex_from[i]) ||
            cap_q[i].to !== 6'(ex_to[i]) || cap_q[i].errc !== 8'(3 + i)) begin
          miscompares++;
          $display("FAIL range_out%0d: act=%0d err=%b %0d->%0d errc=%0d required 15 1 %0d->%0d errc=%0d",
                   i, cap_q[i].act, cap_q[i].err, cap_q[i].from, cap_q[i].to, cap_q[i].errc,
                   ex_from[i], ex_to[i], 3 + i);
        end
      end
    end
    cap_q.delete();
  endtask

  task automatic test_backpressure();
    int ex_act[3] = '{0, 0, 1};
    int ex_to[3] = '{17, 18, 13};
    out_ready = 1'b0;
    send_beat(16, 0);
    send_beat(17, 0);
    in_valid = 1'b1; in_state = 6'd18; in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_action !== 4'd0 ||
          out_from !== 6'd16 || out_to !== 6'd17 || out_last !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: valid=%b in_ready=%b act=%0d %0d->%0d required 1 0 0 16->17",
                 c, out_valid, in_ready, out_action, out_from, out_to);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(18, 0);
    send_beat(13, 1);
    wait_drain(3);
    vectors++;
    if (cap_q.size() != 3) begin
      miscompares++;
      $display("FAIL hold_count: got %0d outputs required 3", cap_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (cap_q[i].act !== 4'(ex_act[i]) || cap_q[i].to !== 6'(ex_to[i]) ||
            cap_q[i].step !== 8'(i + 1) || cap_q[i].last !== (i == 2) || cap_q[i].errc !== 8'd5) begin
          miscompares++;
          $display("FAIL hold_out%0d: act=%0d to=%0d step=%0d last=%b errc=%0d required act=%0d to=%0d step=%0d errc=5",
                   i, cap_q[i].act, cap_q[i].to, cap_q[i].step, cap_q[i].last, cap_q[i].errc,
                   ex_act[i], ex_to[i], i + 1);
        end
      end
    end
    cap_q.delete();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    send_beat(3, 0);
    send_beat(4, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap_q.delete();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || step_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL midrst_state: valid=%b step=%0d errc=%0d required 0 0 0", out_valid, step_cnt, err_cnt);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(12, 0);
    send_beat(13, 1);
    wait_drain(1);
    vectors++;
    if (cap_q.size() != 1 || cap_q[0].act !== 4'd0 || cap_q[0].from !== 6'd12 ||
        cap_q[0].to !== 6'd13 || cap_q[0].last !== 1'b1 || cap_q[0].step !== 8'd1 || cap_q[0].errc !== 8'd0) begin
      miscompares++;
      $display("FAIL midrst_episode: n=%0d act=%0d %0d->%0d last=%b step=%0d required 1 RIGHT 12->13 last=1 step=1",
               cap_q.size(), cap_q[0].act, cap_q[0].from, cap_q[0].to, cap_q[0].last, cap_q[0].step);
    end
    cap_q.delete();
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    send_beat(9, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (cap_q.size() != 0 || out_valid !== 1'b0 || step_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL single_discard: outputs=%0d valid=%b step=%0d required 0 0 1 (held)",
               cap_q.size(), out_valid, step_cnt);
    end
    @(posedge clk);
    #1;
    send_beat(9, 0);
    send_beat(14, 1);
    wait_drain(1);
    vectors++;
    if (cap_q.size() != 1 || cap_q[0].act !== 4'd3 || cap_q[0].err !== 1'b0 ||
        cap_q[0].last !== 1'b1 || cap_q[0].step !== 8'd1) begin
      miscompares++;
      $display("FAIL single_next: n=%0d act=%0d err=%b last=%b step=%0d required 1 DOWN 0 1 1",
               cap_q.size(), cap_q[0].act, cap_q[0].err, cap_q[0].last, cap_q[0].step);
    end
    cap_q.delete();
  endtask

  task automatic test_random();
    obs_t exp_q[$];
    int   offs[5] = '{1, -1, 5, -5, 0};
    int   mprev, ep_trans, merr, lastsent, s, a;
    bit   last;
    bit   rand_done;
    obs_t e;
    do_reset();
    mprev = -1; ep_trans = 0; merr = 0; lastsent = 13; rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 9) < 7) begin
            s = lastsent + offs[$urandom_range(0, 4)];
            if (s < 0 || s > 27) s = $urandom_range(0, 27);
          end else begin
            s = $urandom_range(0, 27);
          end
          last = ($urandom_range(0, 7) == 0);
          send_beat(s, last);
          lastsent = s;
          if (mprev < 0) begin
            if (!last) begin
              mprev = s;
              ep_trans = 0;
            end
          end else begin
            a = ref_action(mprev, s);
            ep_trans++;
            if (a == 15) merr++;
            e = '{4'(a), 6'(mprev), 6'(s), (a == 15), last,
                  8'((ep_trans > 255) ? 255 : ep_trans), 8'((merr > 255) ? 255 : merr)};
            exp_q.push_back(e);
            mprev = last ? -1 : s;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(exp_q.size());
    vectors++;
    if (cap_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d outputs required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      vectors++;
      if (cap_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_out%0d: act=%0d %0d->%0d err=%b last=%b step=%0d errc=%0d required act=%0d %0d->%0d err=%b last=%b step=%0d errc=%0d",
                 i, cap_q[i].act, cap_q[i].from, cap_q[i].to, cap_q[i].err, cap_q[i].last,
                 cap_q[i].step, cap_q[i].errc, exp_q[i].act, exp_q[i].from, exp_q[i].to,
                 exp_q[i].err, exp_q[i].last, exp_q[i].step, exp_q[i].errc);
      end
    end
    cap_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_moves();
    test_illegal_wrap();
    test_out_of_range();
    test_backpressure();
    test_mid_reset();
    test_single_beat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
